// File: rtl/pipe_de_fwd_if.sv
// rtl/pipe_de_fwd_if.sv - D/E pipeline register bus: D-stage inputs, hazard controls, M/W dest info, E-stage outputs
//
// Signals
//   D side   : PC_D, RD1_D, RD2_D, imm32_D, rs_D, rt_D, A3_D, ALUOp_D, BSel_D, RegWrite_D, Tnew_D
//   control  : stall, flush, hold_E
//   M/W info : A3_M, RegWrite_M, A3_W, RegWrite_W
//   E side   : PC_E, RD1_E, RD2_E, imm32_E, rs_E, rt_E, A3_E, ALUOp_E, BSel_E, RegWrite_E,
//              valid_E, Tnew_E, MF_ALUA_Sel, MF_ALUB_Sel
// Modports
//   master : the core side, drives D/control/M/W, reads E
//   slave  : the pipeline register itself

interface pipe_de_fwd_if;
  logic        stall;
  logic        flush;
  logic        hold_E;

  logic [31:0] PC_D;
  logic [31:0] RD1_D;
  logic [31:0] RD2_D;
  logic [31:0] imm32_D;
  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [4:0]  A3_D;
  logic [1:0]  ALUOp_D;
  logic        BSel_D;
  logic        RegWrite_D;
  logic [1:0]  Tnew_D;

  logic [4:0]  A3_M;
  logic        RegWrite_M;
  logic [4:0]  A3_W;
  logic        RegWrite_W;

  logic [31:0] PC_E;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] imm32_E;
  logic [4:0]  rs_E;
  logic [4:0]  rt_E;
  logic [4:0]  A3_E;
  logic [1:0]  ALUOp_E;
  logic        BSel_E;
  logic        RegWrite_E;
  logic        valid_E;
  logic [1:0]  Tnew_E;
  logic [1:0]  MF_ALUA_Sel;
  logic [1:0]  MF_ALUB_Sel;

  modport master (
    output stall, flush, hold_E,
    output PC_D, RD1_D, RD2_D, imm32_D, rs_D, rt_D, A3_D, ALUOp_D, BSel_D, RegWrite_D, Tnew_D,
    output A3_M, RegWrite_M, A3_W, RegWrite_W,
    input  PC_E, RD1_E, RD2_E, imm32_E, rs_E, rt_E, A3_E, ALUOp_E, BSel_E, RegWrite_E,
    input  valid_E, Tnew_E, MF_ALUA_Sel, MF_ALUB_Sel
  );

  modport slave (
    input  stall, flush, hold_E,
    input  PC_D, RD1_D, RD2_D, imm32_D, rs_D, rt_D, A3_D, ALUOp_D, BSel_D, RegWrite_D, Tnew_D,
    input  A3_M, RegWrite_M, A3_W, RegWrite_W,
    output PC_E, RD1_E, RD2_E, imm32_E, rs_E, rt_E, A3_E, ALUOp_E, BSel_E, RegWrite_E,
    output valid_E, Tnew_E, MF_ALUA_Sel, MF_ALUB_Sel
  );
endinterface

// File: rtl/pipe_de_fwd.sv
// rtl/pipe_de_fwd.sv - MIPS D/E pipeline register with E-stage forwarding select generation
//
// Ports
//   clk        : core clock, rising edge
//   reset      : asynchronous, active-low
//   bus        : pipe_de_fwd_if.slave (D inputs, stall/flush/hold_E, M/W dest info, E outputs)
//   bubble_cnt : [31:0] edges that loaded a bubble       (only with PIPE_DE_STATS_EN)
//   hold_cnt   : [31:0] edges that held E (flush low)     (only with PIPE_DE_STATS_EN)
// Configuration macro: PIPE_DE_STATS_EN adds the two statistics counters.

module pipe_de_fwd #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic          clk,
  input  logic          reset,
  pipe_de_fwd_if.slave  bus
`ifdef PIPE_DE_STATS_EN
  ,
  output logic [31:0]   bubble_cnt,
  output logic [31:0]   hold_cnt
`endif
);

  // pc is the first (most significant) field so the bubble constant below can
  // be built by concatenation.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  a3;
    logic [1:0]  alu_op;
    logic        bsel;
    logic        reg_write;
    logic [1:0]  tnew;
    logic        valid;
  } e_regs_t;

  localparam int EW = $bits(e_regs_t);
  localparam e_regs_t E_BUBBLE = e_regs_t'({RESET_PC, {(EW - 32){1'b0}}});

  e_regs_t e_q, e_d;

  always_comb begin
    e_d = e_q;
    if (bus.flush) begin
      e_d = E_BUBBLE;
    end else if (bus.hold_E) begin
      e_d = e_q;
    end else if (bus.stall) begin
      e_d = E_BUBBLE;
    end else begin
      e_d.pc        = bus.PC_D;
      e_d.rd1       = bus.RD1_D;
      e_d.rd2       = bus.RD2_D;
      e_d.imm       = bus.imm32_D;
      e_d.rs        = bus.rs_D;
      e_d.rt        = bus.rt_D;
      e_d.a3        = bus.A3_D;
      e_d.alu_op    = bus.ALUOp_D;
      e_d.bsel      = bus.BSel_D;
      e_d.reg_write = bus.RegWrite_D;
      // One stage of the result latency is consumed by D; never wrap below 0.
      e_d.tnew      = (bus.Tnew_D == 2'd0) ? 2'd0 : bus.Tnew_D - 2'd1;
      e_d.valid     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= E_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  // M result is younger than W, so it wins; $0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] a3_m, input logic we_m,
                                         input logic [4:0] a3_w, input logic we_w);
    if (src != 5'd0 && we_m && a3_m == src) return 2'b10;
    if (src != 5'd0 && we_w && a3_w == src) return 2'b01;
    return 2'b00;
  endfunction

  assign bus.MF_ALUA_Sel = fwd_sel(e_q.rs, bus.A3_M, bus.RegWrite_M, bus.A3_W, bus.RegWrite_W);
  assign bus.MF_ALUB_Sel = fwd_sel(e_q.rt, bus.A3_M, bus.RegWrite_M, bus.A3_W, bus.RegWrite_W);

  assign bus.PC_E       = e_q.pc;
  assign bus.RD1_E      = e_q.rd1;
  assign bus.RD2_E      = e_q.rd2;
  assign bus.imm32_E    = e_q.imm;
  assign bus.rs_E       = e_q.rs;
  assign bus.rt_E       = e_q.rt;
  assign bus.A3_E       = e_q.a3;
  assign bus.ALUOp_E    = e_q.alu_op;
  assign bus.BSel_E     = e_q.bsel;
  assign bus.RegWrite_E = e_q.reg_write;
  assign bus.Tnew_E     = e_q.tnew;
  assign bus.valid_E    = e_q.valid;

`ifdef PIPE_DE_STATS_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;

  // Counters wrap naturally at 2^32.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (bus.flush || (bus.stall && !bus.hold_E)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (bus.hold_E && !bus.flush)                hold_cnt_d   = hold_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_q <= 32'd0;
      hold_cnt_q   <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_de_fwd.sv
// tb/tb_pipe_de_fwd.sv - directed self-checking bench for pipe_de_fwd

module tb_pipe_de_fwd;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  pipe_de_fwd_if bus ();

`ifdef PIPE_DE_STATS_EN
  logic [31:0] bubble_cnt;
  logic [31:0] hold_cnt;
`endif

  pipe_de_fwd #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_DE_STATS_EN
    ,
    .bubble_cnt (bubble_cnt),
    .hold_cnt   (hold_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] a3, input logic [1:0] aluop, input logic bsel,
                         input logic rw, input logic [1:0] tnew);
    bus.PC_D = pc;  bus.RD1_D = rd1;  bus.RD2_D = rd2;  bus.imm32_D = imm;
    bus.rs_D = rs;  bus.rt_D = rt;    bus.A3_D = a3;    bus.ALUOp_D = aluop;
    bus.BSel_D = bsel;  bus.RegWrite_D = rw;  bus.Tnew_D = tnew;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_pc"},    bus.PC_E, 32'h0000_3000);
    check({tag, "_rd1"},   bus.RD1_E, 32'd0);
    check({tag, "_valid"}, {31'd0, bus.valid_E}, 32'd0);
    check({tag, "_rw"},    {31'd0, bus.RegWrite_E}, 32'd0);
    check({tag, "_rs"},    {27'd0, bus.rs_E}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b0;
    bus.stall = 1'b0;  bus.flush = 1'b0;  bus.hold_E = 1'b0;
    bus.A3_M = 5'd0;   bus.RegWrite_M = 1'b0;
    bus.A3_W = 5'd0;   bus.RegWrite_W = 1'b0;
    drive_d(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 2'd0);

    // reset state
    #12;
    check_bubble("rst");
    check("rst_tnew", {30'd0, bus.Tnew_E}, 32'd0);
    check("rst_sela", {30'd0, bus.MF_ALUA_Sel}, 32'd0);
    reset = 1'b1;

    // normal load, Tnew 2 -> 1
    drive_d(32'h3004, 32'd5, 32'd7, 32'h1234, 5'd8, 5'd3, 5'd4, 2'd2, 1'b1, 1'b1, 2'd2);
    tick();
    check("ld_pc",    bus.PC_E, 32'h3004);
    check("ld_rd1",   bus.RD1_E, 32'd5);
    check("ld_rd2",   bus.RD2_E, 32'd7);
    check("ld_imm",   bus.imm32_E, 32'h1234);
    check("ld_rs",    {27'd0, bus.rs_E}, 32'd8);
    check("ld_rt",    {27'd0, bus.rt_E}, 32'd3);
    check("ld_a3",    {27'd0, bus.A3_E}, 32'd4);
    check("ld_aluop", {30'd0, bus.ALUOp_E}, 32'd2);
    check("ld_bsel",  {31'd0, bus.BSel_E}, 32'd1);
    check("ld_rw",    {31'd0, bus.RegWrite_E}, 32'd1);
    check("ld_tnew2", {30'd0, bus.Tnew_E}, 32'd1);
    check("ld_valid", {31'd0, bus.valid_E}, 32'd1);

    // Tnew saturating decrement: 0->0, 3->2, 1->0
    bus.Tnew_D = 2'd0;  tick();  check("tnew0", {30'd0, bus.Tnew_E}, 32'd0);
    bus.Tnew_D = 2'd3;  tick();  check("tnew3", {30'd0, bus.Tnew_E}, 32'd2);
    bus.Tnew_D = 2'd1;  tick();  check("tnew1", {30'd0, bus.Tnew_E}, 32'd0);

    // stall -> bubble
    bus.stall = 1'b1;
    tick();
    check_bubble("stall");
    bus.stall = 1'b0;

    // reload, then flush together with hold: flush wins
    drive_d(32'h3008, 32'd11, 32'd12, 32'd13, 5'd1, 5'd2, 5'd3, 2'd1, 1'b0, 1'b1, 2'd1);
    tick();
    check("reld_pc", bus.PC_E, 32'h3008);
    bus.flush = 1'b1;  bus.hold_E = 1'b1;
    tick();
    check_bubble("flush");
    bus.flush = 1'b0;  bus.hold_E = 1'b0;

    // hold for 3 edges while D changes (one edge also has stall, hold beats stall)
    drive_d(32'h3100, 32'hAA, 32'hBB, 32'hCC, 5'd6, 5'd7, 5'd10, 2'd3, 1'b1, 1'b1, 2'd2);
    tick();
    bus.hold_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_d(32'h3200 + 32'(i * 4), 32'(i), 32'(i + 1), 32'(i + 2), 5'd20, 5'd21, 5'd22,
              2'd0, 1'b0, 1'b0, 2'd3);
      bus.stall = (i == 1);
      tick();
      check($sformatf("hold%0d_pc", i), bus.PC_E, 32'h3100);
      check($sformatf("hold%0d_rd1", i), bus.RD1_E, 32'hAA);
      check($sformatf("hold%0d_rs", i), {27'd0, bus.rs_E}, 32'd6);
      check($sformatf("hold%0d_tnew", i), {30'd0, bus.Tnew_E}, 32'd1);
      check($sformatf("hold%0d_valid", i), {31'd0, bus.valid_E}, 32'd1);
    end
    bus.hold_E = 1'b0;  bus.stall = 1'b0;
    tick();
    check("rel_pc",   bus.PC_E, 32'h3208);
    check("rel_rd1",  bus.RD1_E, 32'd2);
    check("rel_tnew", {30'd0, bus.Tnew_E}, 32'd2);

    // forwarding
    drive_d(32'h3300, 32'd1, 32'd2, 32'd3, 5'd9, 5'd0, 5'd1, 2'd0, 1'b0, 1'b1, 2'd0);
    tick();
    bus.A3_M = 5'd9;  bus.RegWrite_M = 1'b1;  bus.A3_W = 5'd9;  bus.RegWrite_W = 1'b1;
    #1;
    check("fwd_a_m", {30'd0, bus.MF_ALUA_Sel}, 32'd2);
    bus.RegWrite_M = 1'b0;
    #1;
    check("fwd_a_w", {30'd0, bus.MF_ALUA_Sel}, 32'd1);
    bus.A3_W = 5'd8;
    #1;
    check("fwd_a_none", {30'd0, bus.MF_ALUA_Sel}, 32'd0);
    bus.A3_M = 5'd0;  bus.RegWrite_M = 1'b1;  bus.A3_W = 5'd0;  bus.RegWrite_W = 1'b1;
    #1;
    check("fwd_b_zero", {30'd0, bus.MF_ALUB_Sel}, 32'd0);
    drive_d(32'h3304, 32'd1, 32'd2, 32'd3, 5'd4, 5'd5, 5'd1, 2'd0, 1'b0, 1'b1, 2'd0);
    bus.A3_M = 5'd4;  bus.RegWrite_M = 1'b1;  bus.A3_W = 5'd5;  bus.RegWrite_W = 1'b1;
    tick();
    check("fwd_b_w", {30'd0, bus.MF_ALUB_Sel}, 32'd1);
    check("fwd_a_m2", {30'd0, bus.MF_ALUA_Sel}, 32'd2);
    bus.RegWrite_W = 1'b0;
    #1;
    check("fwd_b_we0", {30'd0, bus.MF_ALUB_Sel}, 32'd0);

    // asynchronous reset mid-cycle with valid data in E and a live forward
    #2;
    check("pre_rst_sela", {30'd0, bus.MF_ALUA_Sel}, 32'd2);
    reset = 1'b0;
    #1;
    check_bubble("arst");
    check("arst_sela", {30'd0, bus.MF_ALUA_Sel}, 32'd0);
    check("arst_selb", {30'd0, bus.MF_ALUB_Sel}, 32'd0);
    reset = 1'b1;
    bus.A3_M = 5'd0;  bus.RegWrite_M = 1'b0;  bus.A3_W = 5'd0;  bus.RegWrite_W = 1'b0;

`ifdef PIPE_DE_STATS_EN
    check("st_init_b", bubble_cnt, 32'd0);
    check("st_init_h", hold_cnt, 32'd0);
    bus.stall = 1'b1;  tick();  tick();
    bus.stall = 1'b0;  bus.flush = 1'b1;  tick();
    bus.flush = 1'b0;  bus.hold_E = 1'b1;  tick();  tick();  tick();
    bus.hold_E = 1'b0;
    tick();
    check("st_bubble", bubble_cnt, 32'd3);
    check("st_hold", hold_cnt, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("st_rst_b", bubble_cnt, 32'd0);
    check("st_rst_h", hold_cnt, 32'd0);
    reset = 1'b1;
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
